// File: rtl/adaptive_gain_scaler.sv
// Adaptive gain scaler: signed sample x (G+1), then a programmable left or
// arithmetic-right shift, saturated back to DATA_WIDTH. Three register ranks
// give a fixed two-clock latency from the accepting edge to the output edge.
module adaptive_gain_scaler #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic [7:0]            gain_control,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid_out
);

  // Product needs DATA_WIDTH+4 bits for a 16x gain; one spare bit kept.
  localparam int unsigned PROD_W  = DATA_WIDTH + 5;
  // A left shift of up to 7 on the product must not drop any bits.
  localparam int unsigned SHIFT_W = PROD_W + 7;
  localparam int unsigned MULT_W  = 5;
  localparam int unsigned HI_W    = SHIFT_W - DATA_WIDTH + 1;

  // Capture rank: sample and its own gain word travel together.
  logic                         cap_valid;
  logic signed [DATA_WIDTH-1:0] cap_sample;
  logic [7:0]                   cap_gain;

  // Product rank: product plus the shift controls of the same sample.
  logic                         prod_valid;
  logic signed [PROD_W-1:0]     prod;
  logic                         prod_dir;
  logic [2:0]                   prod_shamt;

  // Combinational datapath nets.
  logic [MULT_W-1:0]            gain_mult_c;
  logic signed [PROD_W-1:0]     sample_ext_c;
  logic signed [PROD_W-1:0]     mult_ext_c;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [SHIFT_W-1:0]    shift_in_c;
  logic signed [SHIFT_W-1:0]    shifted_c;
  logic [HI_W-1:0]              shifted_hi_c;
  logic                         fits_c;
  logic [DATA_WIDTH-1:0]        sat_c;

  // Capture the sample together with its gain word; reset drops everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid  <= 1'b0;
      cap_sample <= '0;
      cap_gain   <= '0;
    end else begin
      cap_valid <= sample_valid_in;
      if (sample_valid_in) begin
        cap_sample <= signed'(sample_in);
        cap_gain   <= gain_control;
      end
    end
  end

  // Multiplier G+1 is 1..16, zero-extended so it stays positive.
  always_comb begin
    gain_mult_c  = MULT_W'({1'b0, cap_gain[7:4]}) + MULT_W'(1);
    sample_ext_c = {{(PROD_W - DATA_WIDTH){cap_sample[DATA_WIDTH-1]}}, cap_sample};
    mult_ext_c   = signed'({{(PROD_W - MULT_W){1'b0}}, gain_mult_c});
    prod_c       = sample_ext_c * mult_ext_c;
  end

  // Register the exact product and the shift controls that go with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid <= 1'b0;
      prod       <= '0;
      prod_dir   <= 1'b0;
      prod_shamt <= '0;
    end else begin
      prod_valid <= cap_valid;
      if (cap_valid) begin
        prod       <= prod_c;
        prod_dir   <= cap_gain[3];
        prod_shamt <= cap_gain[2:0];
      end
    end
  end

  // Shift on a sign-extended copy wide enough that no bit is lost.
  always_comb begin
    shift_in_c = {{(SHIFT_W - PROD_W){prod[PROD_W-1]}}, prod};
    if (prod_dir) begin
      shifted_c = shift_in_c >>> prod_shamt;
    end else begin
      shifted_c = shift_in_c << prod_shamt;
    end
  end

  // Value fits when every bit from the output sign bit upward agrees.
  always_comb begin
    shifted_hi_c = shifted_c[SHIFT_W-1:DATA_WIDTH-1];
    fits_c       = (&shifted_hi_c) | ~(|shifted_hi_c);
    if (fits_c) begin
      sat_c = shifted_c[DATA_WIDTH-1:0];
    end else if (shifted_c[SHIFT_W-1]) begin
      sat_c = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      sat_c = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  end

  // Output rank: update only for a real sample, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= prod_valid;
      if (prod_valid) begin
        sample_out <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_adaptive_gain_scaler.sv
// Directed and table-driven checks of adaptive_gain_scaler against a
// 64-bit integer reference and a two-deep latency model.
module tb_adaptive_gain_scaler;

  logic        clk;
  logic        rst;
  logic [31:0] sample_in;
  logic        sample_valid_in;
  logic [7:0]  gain_control;
  logic [31:0] sample_out;
  logic        sample_valid_out;

  int n_cmp;
  int n_bad;

  // Expected pipeline contents (stage 0, stage 1) and expected outputs.
  logic        pv0, pv1;
  logic [31:0] pd0, pd1;
  logic        exp_v;
  logic [31:0] exp_d;

  adaptive_gain_scaler #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .gain_control     (gain_control),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_scale(input logic [31:0] s, input logic [7:0] g);
    longint p;
    longint q;
    longint m;
    m = longint'(g[7:4]) + 64'sd1;
    p = longint'($signed(s)) * m;
    if (g[3]) q = p >>> g[2:0];
    else      q = p <<< g[2:0];
    if (q > 64'sd2147483647)       return 32'h7FFF_FFFF;
    else if (q < -64'sd2147483648) return 32'h8000_0000;
    else                           return q[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model on posedge, check #1 after.
  task automatic step(input logic r, input logic v, input logic [31:0] s, input logic [7:0] g);
    @(negedge clk);
    rst             = r;
    sample_valid_in = v;
    sample_in       = s;
    gain_control    = g;
    @(posedge clk);
    #1;
    if (r) begin
      pv0 = 1'b0; pv1 = 1'b0; pd0 = '0; pd1 = '0;
      exp_v = 1'b0; exp_d = '0;
    end else begin
      exp_v = pv1;
      if (pv1) exp_d = pd1;
      pv1 = pv0; pd1 = pd0;
      pv0 = v;   pd0 = ref_scale(s, g);
    end
    chk("valid_model", 32'(sample_valid_out), 32'(exp_v));
    chk("data_model", sample_out, exp_d);
  endtask

  initial begin
    logic [31:0] rs;
    logic [31:0] corner [4];
    n_cmp = 0; n_bad = 0;
    pv0 = 0; pv1 = 0; pd0 = 0; pd1 = 0; exp_v = 0; exp_d = 0;
    rst = 1'b1; sample_valid_in = 1'b0; sample_in = '0; gain_control = '0;
    corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000;
    corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0000_0001;

    // Reset with valid asserted must be ignored.
    step(1, 1, 32'h1234_5678, 8'hF0);
    step(1, 1, 32'h1234_5678, 8'hF0);
    chk("reset_out", sample_out, 32'h0);
    chk("reset_valid", 32'(sample_valid_out), 32'h0);

    // 0x1000 x9 <<1 = 0x12000, two cycles after acceptance, then held.
    step(0, 1, 32'h0000_1000, 8'h81);
    chk("s1_lat0", 32'(sample_valid_out), 32'h0);
    step(0, 0, 32'hDEAD_BEEF, 8'hFF);
    chk("s1_lat1", 32'(sample_valid_out), 32'h0);
    step(0, 0, 32'hDEAD_BEEF, 8'hFF);
    chk("s1_valid", 32'(sample_valid_out), 32'h1);
    chk("s1_data", sample_out, 32'h0001_2000);
    step(0, 0, 32'h0, 8'h0);
    chk("s1_strobe_end", 32'(sample_valid_out), 32'h0);
    chk("s1_hold", sample_out, 32'h0001_2000);

    // Positive saturation.
    step(0, 1, 32'h7FFF_FFFF, 8'hF7);
    step(0, 0, 32'h0, 8'h0);
    step(0, 0, 32'h0, 8'h0);
    chk("sat_pos", sample_out, 32'h7FFF_FFFF);

    // Negative saturation.
    step(0, 1, 32'h8000_0000, 8'h10);
    step(0, 0, 32'h0, 8'h0);
    step(0, 0, 32'h0, 8'h0);
    chk("sat_neg", sample_out, 32'h8000_0000);

    // Arithmetic right shift of a negative sample.
    step(0, 1, 32'hFFFF_F000, 8'h0A);
    step(0, 0, 32'h0, 8'h0);
    step(0, 0, 32'h0, 8'h0);
    chk("rshift_neg", sample_out, 32'hFFFF_FC00);

    // Back-to-back unity gain: 1, 2, 3 on consecutive cycles.
    step(0, 1, 32'd1, 8'h00);
    step(0, 1, 32'd2, 8'h00);
    step(0, 1, 32'd3, 8'h00);
    chk("b2b_1", sample_out, 32'd1);
    chk("b2b_1v", 32'(sample_valid_out), 32'h1);
    step(0, 0, 32'd9, 8'h00);
    chk("b2b_2", sample_out, 32'd2);
    chk("b2b_2v", 32'(sample_valid_out), 32'h1);
    step(0, 0, 32'd9, 8'h00);
    chk("b2b_3", sample_out, 32'd3);
    chk("b2b_3v", 32'(sample_valid_out), 32'h1);
    step(0, 0, 32'd9, 8'h00);
    chk("b2b_end", 32'(sample_valid_out), 32'h0);

    // Sample accepted, then reset on the next edge: nothing emerges.
    step(0, 1, 32'h0000_0100, 8'h00);
    step(1, 1, 32'h0000_0200, 8'h00);
    chk("rst_mid_out", sample_out, 32'h0);
    step(0, 0, 32'h0, 8'h00);
    chk("rst_mid_v1", 32'(sample_valid_out), 32'h0);
    step(0, 0, 32'h0, 8'h00);
    chk("rst_mid_v2", 32'(sample_valid_out), 32'h0);
    chk("rst_mid_out2", sample_out, 32'h0);

    // Sample on the first edge after reset release is accepted.
    step(1, 0, 32'h0, 8'h00);
    step(0, 1, 32'h0000_0055, 8'h0F);
    step(0, 0, 32'h0, 8'h00);
    step(0, 0, 32'h0, 8'h00);
    chk("post_rst", sample_out, 32'h0000_0000);
    chk("post_rst_v", 32'(sample_valid_out), 32'h1);
    step(0, 1, 32'h0000_0055, 8'h00);
    step(0, 0, 32'h0, 8'h00);
    step(0, 0, 32'h0, 8'h00);
    chk("unity", sample_out, 32'h0000_0055);

    // All 256 gain codes streamed back-to-back with random samples.
    for (int i = 0; i < 256; i++) begin
      rs = (i % 8 == 0) ? corner[(i / 8) % 4] : $urandom;
      step(0, 1, rs, 8'(i));
    end
    // Random valid gaps and random gain words.
    for (int i = 0; i < 300; i++) begin
      rs = ($urandom_range(0, 9) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      step(0, 1'($urandom_range(0, 1)), rs, 8'($urandom));
    end
    step(0, 0, 32'h0, 8'h00);
    step(0, 0, 32'h0, 8'h00);
    step(0, 0, 32'h0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
